// File: rtl/timer_sched_pkg.sv
// Shared state encoding and TIMER default constants
// for the timer burst scheduler.
package timer_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      GAP
   } state_t;

   localparam int FULL_CYCLE       = 23;
   localparam int COLD_BOOT_CYCLE  = 20;
   localparam int OUTPUT_UP_PERIOD = 16;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or
// after ptr, wrapping round.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   always_comb begin
      logic found;
      int   j;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/timer_sched.sv
// Shares one TIMER among NUM_REQ requesters: round-robin
// bursts of whole periods, watchdog abort, cold-boot gap.
module timer_sched #(
   parameter int NUM_REQ     = 2,
   parameter int PW          = 4,
   parameter int FULL_CYCLE  = timer_sched_pkg::FULL_CYCLE,
   parameter int WDOG_CYCLES = 64,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*PW-1:0] req_periods,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic [NUM_REQ-1:0]    err,
   output logic                  busy,
   output logic                  timer_en,
   input  logic [4:0]            tmr_valid_count,
   input  logic                  tmr_low_started
);

   import timer_sched_pkg::*;

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   state_t state, state_n;

   logic [NUM_REQ-1:0] grant_n, done_n, err_n, pick_oh;
   logic               busy_n, en_n;
   logic [IW-1:0]      ptr, ptr_n, owner, owner_n, pick_idx;
   logic [PW-1:0]      remaining, remaining_n, pick_per;
   logic [WW-1:0]      wdog, wdog_n;
   logic [GW-1:0]      gcnt, gcnt_n;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );

   assign pick_per = req_periods[int'(pick_idx)*PW +: PW];

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      done_n      = '0;
      err_n       = '0;
      en_n        = timer_en;
      ptr_n       = ptr;
      owner_n     = owner;
      remaining_n = remaining;
      wdog_n      = wdog;
      gcnt_n      = gcnt;
      unique case (state)
         IDLE: begin
            if (|req) begin
               grant_n     = pick_oh;
               owner_n     = pick_idx;
               ptr_n       = (pick_idx == IW'(NUM_REQ - 1)) ?
                             '0 : pick_idx + 1'b1;
               wdog_n      = '0;
               remaining_n = pick_per;
               if (pick_per == '0) begin
                  done_n  = pick_oh;
                  state_n = GAP;
               end else begin
                  en_n    = 1'b1;
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            // expiry exits RUN, so wdog never passes WDOG_CYCLES
            if (wdog == WW'(WDOG_CYCLES) && !tmr_low_started) begin
               err_n   = grant;
               state_n = GAP;
            end else if (!req[owner]) begin
               state_n = GAP;
            end else if (tmr_low_started) begin
               wdog_n      = '0;
               remaining_n = remaining - 1'b1;
               if (remaining == PW'(1)) state_n = DRAIN;
            end else begin
               wdog_n = wdog + 1'b1;
            end
         end
         DRAIN: begin
            if (tmr_valid_count == 5'(FULL_CYCLE)) begin
               done_n  = grant;
               state_n = GAP;
            end else if (!req[owner]) begin
               state_n = GAP;
            end
         end
         GAP: begin
            if (gcnt == GW'(GAP_CYCLES)) state_n = IDLE;
            else gcnt_n = gcnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // a zero-length grant keeps grant up alongside its done
      if (state != GAP && state_n == GAP) begin
         en_n   = 1'b0;
         gcnt_n = '0;
         if (state != IDLE) grant_n = '0;
      end
      if (state == GAP) begin
         grant_n = '0;
         en_n    = 1'b0;
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         done      <= '0;
         err       <= '0;
         busy      <= 1'b0;
         timer_en  <= 1'b0;
         ptr       <= '0;
         owner     <= '0;
         remaining <= '0;
         wdog      <= '0;
         gcnt      <= '0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         done      <= done_n;
         err       <= err_n;
         busy      <= busy_n;
         timer_en  <= en_n;
         ptr       <= ptr_n;
         owner     <= owner_n;
         remaining <= remaining_n;
         wdog      <= wdog_n;
         gcnt      <= gcnt_n;
      end
   end

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: burst-level reference
// model, TIMER stub, directed and randomized stimulus.
module tb_timer_sched;

   localparam int N    = 2;
   localparam int PW   = 4;
   localparam int FULL = 23;
   localparam int WDOG = 64;
   localparam int GAPC = 2;

   localparam int K_DONE = 0;
   localparam int K_ERR  = 1;
   localparam int K_DROP = 2;
   localparam int K_ZERO = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*PW-1:0] req_periods = '0;
   logic [N-1:0]    grant, done, err;
   logic            busy, timer_en;
   logic [4:0]      vc;
   logic            ls;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // reference model: one burst record with arithmetic end time
   int m_own  = -1;
   int m_g    = 0;
   int m_e    = 0;
   int m_kind = 0;
   int m_idle = 0;
   int m_ptr  = 0;

   // TIMER stub: cold boots whenever en is low
   int en_cnt = 0;
   bit stub_dead = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) en_cnt <= timer_en ? en_cnt + 1 : 0;

   assign ls = timer_en && !stub_dead && en_cnt >= 37 &&
               ((en_cnt - 37) % 24) == 0;
   assign vc = (!timer_en || en_cnt < 21) ?
               5'd0 : 5'((en_cnt - 21) % 24);

   timer_sched #(
      .NUM_REQ     (N),
      .PW          (PW),
      .FULL_CYCLE  (FULL),
      .WDOG_CYCLES (WDOG),
      .GAP_CYCLES  (GAPC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req             (req),
      .req_periods     (req_periods),
      .grant           (grant),
      .done            (done),
      .err             (err),
      .busy            (busy),
      .timer_en        (timer_en),
      .tmr_valid_count (vc),
      .tmr_low_started (ls)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d",
                  nm, cyc, act, exp);
      end
   endtask

   function automatic logic [3*N+1:0] exp_out(int c);
      logic [N-1:0] oh, gr, dn, er;
      logic         b, en;
      gr = '0; dn = '0; er = '0; b = 1'b0; en = 1'b0;
      oh = (m_own >= 0) ? (N'(1) << m_own) : '0;
      if (m_own >= 0 && c < m_e) begin
         gr = oh; en = 1'b1; b = 1'b1;
      end else if (m_own >= 0 && c == m_e) begin
         b = 1'b1;
         if (m_kind == K_ZERO) begin gr = oh; dn = oh; end
         else if (m_kind == K_DONE) dn = oh;
         else if (m_kind == K_ERR) er = oh;
      end else if (c < m_idle) begin
         b = 1'b1;
      end
      return {gr, dn, er, b, en};
   endfunction

   // decisions taken at the clock edge that ends cycle c
   task automatic model_step(int c);
      int j, n;
      if (m_own >= 0 && m_kind != K_ZERO && c >= m_g &&
          c <= m_e - 2 && !req[m_own]) begin
         m_e    = c + 1;
         m_kind = K_DROP;
         m_idle = m_e + GAPC + 1;
      end
      if (c >= m_idle && req != '0) begin
         j = -1;
         for (int k = 0; k < N; k++)
            if (j < 0 && req[(m_ptr + k) % N]) j = (m_ptr + k) % N;
         n     = int'(req_periods[j*PW +: PW]);
         m_own = j;
         m_g   = c + 1;
         if (n == 0) begin
            m_e = m_g; m_kind = K_ZERO;
         end else if (stub_dead) begin
            m_e = m_g + WDOG + 1; m_kind = K_ERR;
         end else begin
            m_e = m_g + 45 + 24 * (n - 1); m_kind = K_DONE;
         end
         m_idle = m_e + GAPC + 1;
         m_ptr  = (j + 1) % N;
      end
   endtask

   always @(negedge clk)
      if (rst_n)
         check("cycle_outputs", {grant, done, err, busy, timer_en},
               exp_out(cyc));

   task automatic tick();
      model_step(cyc);
      @(negedge clk);
      #1;
   endtask

   task automatic set_per(int i, int v);
      req_periods[i*PW +: PW] = PW'(v);
   endtask

   task automatic wait_grant(output int gc, input logic [N-1:0] ex,
                             input string nm);
      gc = -1;
      for (int k = 0; k < 40; k++) begin
         if (grant != '0) begin
            gc = cyc;
            break;
         end
         tick();
      end
      check(nm, grant, ex);
   endtask

   task automatic rand_run(int ncyc, bit dead);
      bit active;
      req = '0;
      for (int k = 0; k < 600 && cyc < m_idle; k++) tick();
      check("rand_idle_reached", cyc >= m_idle, 1);
      stub_dead = dead;
      for (int n = 0; n < ncyc; n++) begin
         for (int i = 0; i < N; i++) begin
            active = (m_own == i && cyc >= m_g && cyc < m_e);
            if (active) begin
               if ($urandom_range(0, 199) == 0) req[i] = 1'b0;
               if ($urandom_range(0, 3) == 0)
                  set_per(i, int'($urandom_range(0, 3)));
            end else if (!req[i]) begin
               if ($urandom_range(0, 5) == 0) begin
                  req[i] = 1'b1;
                  set_per(i, int'($urandom_range(0, 3)));
               end
            end else if (m_own == i && cyc >= m_e) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            end
         end
         tick();
      end
      req = '0;
      for (int k = 0; k < 600 && cyc < m_idle; k++) tick();
      stub_dead = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout @cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int g, g2, d, ea;
      int en_first, en_last, ls1, ls2, dn, bl;
      bit seen, en_seen;
      logic [N-1:0] errv, rr_exp[4];
      logic en_at;
      rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

      repeat (3) @(negedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_timer_en", timer_en, 0);
      rst_n  = 1'b1;
      m_idle = cyc;
      tick();

      // period count: 2-period burst for requester 0
      req = 2'b01;
      set_per(0, 2);
      tick();
      wait_grant(g, 2'b01, "t1_grant");
      en_first = -1; en_last = -1; ls1 = -1; ls2 = -1;
      dn = -1; bl = -1;
      for (int k = 0; k < 80; k++) begin
         if (timer_en) begin
            if (en_first < 0) en_first = k;
            en_last = k;
         end
         if (ls) begin
            if (ls1 < 0) ls1 = k;
            else if (ls2 < 0) ls2 = k;
         end
         if (done[0] && dn < 0) begin
            dn  = k;
            req = '0;
         end
         if (!busy && bl < 0) bl = k;
         tick();
      end
      check("t1_en_first", en_first, 0);
      check("t1_en_last", en_last, 68);
      check("t1_ls_first", ls1, 37);
      check("t1_ls_second", ls2, 61);
      check("t1_done_cycle", dn, 69);
      check("t1_busy_low", bl, 72);

      // asynchronous reset mid-burst, pointer left at 1
      req = 2'b01;
      set_per(0, 3);
      tick();
      wait_grant(g, 2'b01, "rst_pre_grant");
      for (int k = 0; k < 40; k++) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_outputs", {grant, done, err, busy, timer_en}, 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      req = 2'b11;
      set_per(0, 1);
      set_per(1, 1);
      m_own  = -1;
      m_ptr  = 0;
      m_idle = cyc;
      rst_n  = 1'b1;
      tick();

      // round robin: first grant after reset goes to requester 0
      for (int r = 0; r < 4; r++) begin
         wait_grant(g, rr_exp[r], "rr_grant");
         d = -1;
         for (int k = 0; k < 60; k++) begin
            if (done != '0) begin
               d = cyc;
               break;
            end
            tick();
         end
         check("rr_done_latency", d - g, 45);
         check("rr_done_vec", done, rr_exp[r]);
         if (r == 3) req = '0;
         tick();
      end

      // zero-length request
      req = 2'b10;
      set_per(1, 0);
      tick();
      wait_grant(g, 2'b10, "zero_grant");
      check("zero_done", done, 2'b10);
      req = '0;
      en_seen = timer_en;
      for (int k = 0; k < 6; k++) begin
         tick();
         en_seen = en_seen | timer_en;
      end
      check("zero_en_never", en_seen, 0);

      // watchdog with a TIMER that never pulses
      stub_dead = 1'b1;
      req = 2'b01;
      set_per(0, 2);
      tick();
      wait_grant(g, 2'b01, "wd_grant");
      ea = -1; seen = 1'b0; errv = '0; en_at = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (done != '0) seen = 1'b1;
         if (err != '0) begin
            ea = cyc - g; errv = err; en_at = timer_en;
            break;
         end
         tick();
      end
      check("wd_err_latency", ea, 65);
      check("wd_err_vec", errv, 2'b01);
      check("wd_en_low", en_at, 0);
      check("wd_no_done", seen, 0);
      req = '0;
      tick();
      stub_dead = 1'b0;

      // requester drop at cycle 50 of a 3-period burst
      req = 2'b01;
      set_per(0, 3);
      tick();
      wait_grant(g, 2'b01, "drop_grant");
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (done != '0 || err != '0) seen = 1'b1;
      end
      req[0] = 1'b0;
      tick();
      check("drop_en_low", timer_en, 0);
      if (done != '0 || err != '0) seen = 1'b1;
      req[1] = 1'b1;
      set_per(1, 1);
      for (int k = 0; k < 40 && grant == '0; k++) begin
         tick();
         if (done != '0 || err != '0) seen = 1'b1;
      end
      g2 = cyc;
      check("drop_no_done_err", seen, 0);
      check("drop_next_grant_vec", grant, 2'b10);
      check("drop_next_grant_at", g2 - g, 55);
      req = '0;

      rand_run(3000, 1'b0);
      rand_run(800, 1'b1);
      rand_run(600, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
